inst_sram_responder: RTL

//  Responder end of the instruction-fetch request/ack handshake. Accepts a fetch

---
 rtl/inst_sram_responder.sv | 98 +++++++++
 1 files changed

// File: rtl/inst_sram_responder.sv
// rtl/inst_sram_responder.sv - instruction-fetch responder over a 1-cycle synchronous SRAM
// Registered Moore FSM: IDLE -> READ -> CAPT -> WAIT -> RESP, with misaligned pcs short-circuiting to RESP.
module inst_sram_responder #(
  parameter int ADDR_W      = 14,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req_valid,
  input  logic [31:0]       inst_req_pc,
  input  logic              inst_cancel,
  output logic              inst_req_ack,
  output logic [31:0]       inst_rdata,
  output logic              inst_addr_error,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [2:0] {IDLE, READ, CAPT, WAIT, RESP} state_t;

  localparam logic [3:0] WAIT_M1 = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t     state;
  logic [3:0] cnt;

  // High pc bits lie outside the SRAM window and are deliberately dropped.
  logic unused_pc_hi;
  assign unused_pc_hi = ^inst_req_pc[31:ADDR_W+2];

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      inst_req_ack    <= 1'b0;
      inst_rdata      <= 32'h0;
      inst_addr_error <= 1'b0;
      sram_en         <= 1'b0;
      sram_addr       <= '0;
      cnt             <= 4'd0;
    end else begin
      inst_req_ack <= 1'b0;
      sram_en      <= 1'b0;
      case (state)
        IDLE: begin
          if (inst_req_valid && !inst_cancel) begin
            if (inst_req_pc[1:0] != 2'b00) begin
              inst_addr_error <= 1'b1;
              inst_rdata      <= 32'h0;
              inst_req_ack    <= 1'b1;
              state           <= RESP;
            end else begin
              // Address is registered with the enable so sram_addr only moves when a read issues.
              inst_addr_error <= 1'b0;
              sram_en         <= 1'b1;
              sram_addr       <= inst_req_pc[ADDR_W+1:2];
              state           <= READ;
            end
          end
        end
        READ: begin
          state <= inst_cancel ? IDLE : CAPT;
        end
        CAPT: begin
          if (inst_cancel) begin
            state <= IDLE;
          end else begin
            inst_rdata <= sram_rdata;
            if (WAIT_CYCLES > 0) begin
              cnt   <= WAIT_M1;
              state <= WAIT;
            end else begin
              inst_req_ack <= 1'b1;
              state        <= RESP;
            end
          end
        end
        WAIT: begin
          if (inst_cancel) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            inst_req_ack <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          // Ack is already on the wire this cycle; a cancel here cannot retract it.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
